// File: rtl/delay_pkg.sv
// Shared types and default sizing for the delay timer bank.
//   dly_mode_e : per-channel behaviour at terminal count (wrap or park)
//   CBITS_DEF  : default counter/period width
//   N_DEF      : default period loaded at reset
package delay_pkg;

   typedef enum logic {
      DLY_PERIODIC = 1'b0,
      DLY_ONESHOT  = 1'b1
   } dly_mode_e;

   localparam int unsigned CBITS_DEF = 14;
   localparam int unsigned N_DEF     = 15000;

endpackage

// File: rtl/delay_chan.sv
// One programmable-period delay channel: counts 0..per, flags terminal
// count, then wraps (periodic) or parks with a sticky done (one-shot).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : count enable
//   mode      : DLY_PERIODIC / DLY_ONESHOT
//   ld        : load strobe already decoded for this channel
//   ld_val    : new period
//   sig       : terminal-count indication (cnt == per and not done)
//   err       : cnt > per, sanity flag
//   flg       : cnt < per
//   done      : one-shot completed, sticky until rst/ld
module delay_chan
   import delay_pkg::*;
#(
   parameter int unsigned CBITS     = CBITS_DEF,
   parameter int unsigned DEFAULT_N = N_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  dly_mode_e        mode,
   input  logic             ld,
   input  logic [CBITS-1:0] ld_val,
   output logic             sig,
   output logic             err,
   output logic             flg,
   output logic             done
);

   logic [CBITS-1:0] cnt, cnt_nxt;
   logic [CBITS-1:0] per, per_nxt;
   logic             done_q, done_nxt;

   // Next-state: load beats counting; en=0 holds everything.
   always_comb begin
      cnt_nxt  = cnt;
      per_nxt  = per;
      done_nxt = done_q;
      if (ld) begin
         per_nxt  = ld_val;
         cnt_nxt  = '0;
         done_nxt = 1'b0;
      end else if (en) begin
         if (cnt < per) begin
            cnt_nxt = cnt + CBITS'(1);
         end else if (mode == DLY_PERIODIC) begin
            cnt_nxt = '0;
         end else begin
            done_nxt = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         per    <= CBITS'(DEFAULT_N);
         done_q <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         per    <= per_nxt;
         done_q <= done_nxt;
      end
   end

   // Output decode straight from the registers.
   assign sig  = (cnt == per) && !done_q;
   assign flg  = (cnt < per);
   assign err  = (cnt > per);
   assign done = done_q;

endmodule

// File: rtl/delay_multi_timer.sv
// Bank of NCH independent programmable-period delay channels.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en       : per-channel count enable
//   mode     : per-channel mode (0 periodic, 1 one-shot)
//   ld       : period load strobe
//   ld_ch    : channel addressed by ld (out-of-range values are ignored)
//   ld_val   : new period value
//   sig      : per-channel terminal-count pulse
//   err      : per-channel cnt > period sanity flag
//   flg      : per-channel cnt < period
//   done     : per-channel sticky one-shot completion
//   any_sig  : OR of sig
module delay_multi_timer
   import delay_pkg::*;
#(
   parameter int unsigned NCH       = 4,
   parameter int unsigned CBITS     = CBITS_DEF,
   parameter int unsigned DEFAULT_N = N_DEF
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NCH-1:0]                          en,
   input  logic [NCH-1:0]                          mode,
   input  logic                                    ld,
   input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ld_ch,
   input  logic [CBITS-1:0]                        ld_val,
   output logic [NCH-1:0]                          sig,
   output logic [NCH-1:0]                          err,
   output logic [NCH-1:0]                          flg,
   output logic [NCH-1:0]                          done,
   output logic                                    any_sig
);

   localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

   // Address compare per channel; addresses >= NCH match no channel.
   for (genvar c = 0; c < NCH; c++) begin : g_chan
      logic ld_c;
      assign ld_c = ld && (ld_ch == CHW'(c));

      delay_chan #(
         .CBITS     (CBITS),
         .DEFAULT_N (DEFAULT_N)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .en     (en[c]),
         .mode   (dly_mode_e'(mode[c])),
         .ld     (ld_c),
         .ld_val (ld_val),
         .sig    (sig[c]),
         .err    (err[c]),
         .flg    (flg[c]),
         .done   (done[c])
      );
   end

   assign any_sig = |sig;

endmodule
